// File: rtl/counter_pkg.sv
// Shared types and helpers for the counting primitives.
package counter_pkg;

  typedef enum logic {CNT_DOWN, CNT_UP} cnt_dir_e;
  typedef enum logic {CNT_WRAP, CNT_SAT} cnt_mode_e;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/cnt_prescaler.sv
// Enable prescaler: o_tick on every PRESCALE-th qualified i_en cycle.
// Latency: combinational tick from registered phase; backpressure: none (i_en low holds the phase).
module cnt_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  generate
    if (PRESCALE == 1) begin : g_pass
      logic unused_p1;
      assign unused_p1 = ^{i_clk, i_rst_n, i_clr};
      assign o_tick    = i_en;
    end else begin : g_div
      localparam int PW = clog2_min1(PRESCALE);
      localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

      logic [PW-1:0] phase;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          phase <= '0;
        end else if (i_clr) begin
          phase <= '0;
        end else if (i_en) begin
          phase <= (phase == LAST) ? '0 : phase + PW'(1);
        end
      end

      assign o_tick = i_en & ~i_clr & (phase == LAST);
    end
  endgenerate

endmodule

// File: rtl/updown_counter_n.sv
// Parametrised up/down counter with modulus, wrap/saturate, prescaled enable, tc and sticky ovf.
// Latency: one cycle from sampled control to o_cnt/o_tc; backpressure: none (i_en low holds).
module updown_counter_n
  import counter_pkg::*;
#(
  parameter int W        = 8,
  parameter int MOD      = 2 ** W,
  parameter int PRESCALE = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  input  logic         i_dir,
  input  logic         i_sat,
  output logic [W-1:0] o_cnt,
  output logic         o_full,
  output logic         o_empty,
  output logic         o_tc,
  output logic         o_ovf
);

  generate
    if (MOD < 2 || MOD > (2 ** W)) begin : g_bad_mod
      $error("updown_counter_n: MOD must satisfy 2 <= MOD <= 2**W");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
      $error("updown_counter_n: PRESCALE must be >= 1");
    end
  endgenerate

  // Extended by one bit so MOD = 2**W is representable.
  localparam logic [W:0]   MOD_EXT = (W + 1)'(MOD);
  localparam logic [W-1:0] CNT_MAX = W'(MOD - 1);

  logic [W-1:0] cnt_q, cnt_nxt;
  logic         tc_q, tc_nxt;
  logic         ovf_q, ovf_nxt;
  logic         tick;
  logic         step;
  logic         at_max, at_min;
  logic [W-1:0] load_clamped;
  cnt_dir_e     dir;
  cnt_mode_e    mode;

  cnt_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_clr | i_load),
    .i_en    (i_en),
    .o_tick  (tick)
  );

  assign step         = i_en & tick;
  assign dir          = cnt_dir_e'(i_dir);
  assign mode         = cnt_mode_e'(i_sat);
  assign at_max       = (cnt_q == CNT_MAX);
  assign at_min       = (cnt_q == '0);
  assign load_clamped = ({1'b0, i_load_val} >= MOD_EXT) ? CNT_MAX : i_load_val;

  always_comb begin
    cnt_nxt = cnt_q;
    tc_nxt  = 1'b0;
    ovf_nxt = ovf_q;
    if (i_clr) begin
      cnt_nxt = '0;
      ovf_nxt = 1'b0;
    end else if (i_load) begin
      cnt_nxt = load_clamped;
    end else if (step) begin
      if (dir == CNT_UP) begin
        if (at_max) begin
          cnt_nxt = (mode == CNT_SAT) ? CNT_MAX : '0;
          tc_nxt  = 1'b1;
          ovf_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt_q + W'(1);
        end
      end else begin
        if (at_min) begin
          cnt_nxt = (mode == CNT_SAT) ? '0 : CNT_MAX;
          tc_nxt  = 1'b1;
          ovf_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt_q - W'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_nxt;
      tc_q  <= tc_nxt;
      ovf_q <= ovf_nxt;
    end
  end

  assign o_cnt   = cnt_q;
  assign o_tc    = tc_q;
  assign o_ovf   = ovf_q;
  assign o_full  = at_max;
  assign o_empty = at_min;

endmodule

// File: tb/tb_updown_counter_n.sv
// Directed bench: three counter instances (MOD 10/P 1, MOD 10/P 3, MOD 16/P 1) on shared stimulus.
module tb_updown_counter_n;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       load;
  logic [3:0] load_val;
  logic       en;
  logic       dir;
  logic       sat;

  logic [3:0] a_cnt, p_cnt, f_cnt;
  logic       a_full, a_empty, a_tc, a_ovf;
  logic       p_full, p_empty, p_tc, p_ovf;
  logic       f_full, f_empty, f_tc, f_ovf;

  int n_assert = 0;
  int n_fail   = 0;

  updown_counter_n #(.W(4), .MOD(10), .PRESCALE(1)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_load(load), .i_load_val(load_val),
    .i_en(en), .i_dir(dir), .i_sat(sat),
    .o_cnt(a_cnt), .o_full(a_full), .o_empty(a_empty), .o_tc(a_tc), .o_ovf(a_ovf)
  );

  updown_counter_n #(.W(4), .MOD(10), .PRESCALE(3)) u_p (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_load(load), .i_load_val(load_val),
    .i_en(en), .i_dir(dir), .i_sat(sat),
    .o_cnt(p_cnt), .o_full(p_full), .o_empty(p_empty), .o_tc(p_tc), .o_ovf(p_ovf)
  );

  updown_counter_n #(.W(4), .MOD(16), .PRESCALE(1)) u_f (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_load(load), .i_load_val(load_val),
    .i_en(en), .i_dir(dir), .i_sat(sat),
    .o_cnt(f_cnt), .o_full(f_full), .o_empty(f_empty), .o_tc(f_tc), .o_ovf(f_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; load = 1'b0; load_val = 4'd0;
    en = 1'b0; dir = 1'b0; sat = 1'b0;
    #12;
    chk("rst_cnt",   a_cnt,   0);
    chk("rst_empty", a_empty, 1);
    chk("rst_full",  a_full,  0);
    chk("rst_tc",    a_tc,    0);
    chk("rst_ovf",   a_ovf,   0);

    // Up-wrap on MOD 10, prescale-by-3 tracking on u_p, plain count on u_f.
    rst_n = 1'b1; en = 1'b1; dir = 1'b1; sat = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("up_cnt",  a_cnt,  i % 10);
      chk("up_tc",   a_tc,   (i == 10) ? 1 : 0);
      chk("up_ovf",  a_ovf,  (i >= 10) ? 1 : 0);
      chk("up_full", a_full, (i == 9) ? 1 : 0);
      chk("p3_cnt",  p_cnt,  i / 3);
      chk("f_cnt",   f_cnt,  i);
    end

    // Full-range modulus: 15 -> 0 up, then 0 -> 15 down.
    for (int i = 13; i <= 16; i++) begin
      tick();
      chk("f_upcnt", f_cnt, i % 16);
      chk("f_uptc",  f_tc,  (i == 16) ? 1 : 0);
      chk("a_cnt2",  a_cnt, i % 10);
    end
    dir = 1'b0;
    tick();
    chk("f_dncnt", f_cnt, 15);
    chk("f_dntc",  f_tc,  1);
    chk("f_full",  f_full, 1);
    chk("a_dn",    a_cnt, 5);

    // Climb u_a to 7, then hit it with an asynchronous reset between edges.
    dir = 1'b1;
    tick();
    tick();
    chk("pre_rst_cnt", a_cnt, 7);
    chk("pre_rst_ovf", a_ovf, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_cnt", a_cnt, 0);
    chk("arst_ovf", a_ovf, 0);
    chk("arst_tc",  a_tc,  0);
    chk("arst_p",   p_cnt, 0);
    #2 rst_n = 1'b1;
    tick();
    chk("rel_a1", a_cnt, 1);
    chk("rel_p1", p_cnt, 0);
    tick();
    chk("rel_p2", p_cnt, 0);
    tick();
    chk("rel_p3", p_cnt, 1);
    chk("rel_a3", a_cnt, 3);

    // Saturating down from a load of 2; concurrent i_en ignored on the load.
    load = 1'b1; load_val = 4'd2;
    tick();
    chk("ld2_cnt", a_cnt, 2);
    chk("ld2_ovf", a_ovf, 0);
    load = 1'b0; dir = 1'b0; sat = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("sat_cnt",   a_cnt,   (i == 1) ? 1 : 0);
      chk("sat_tc",    a_tc,    (i >= 3) ? 1 : 0);
      chk("sat_ovf",   a_ovf,   (i >= 3) ? 1 : 0);
      chk("sat_empty", a_empty, (i >= 2) ? 1 : 0);
    end

    // Load clamp, then clear beating load.
    en = 1'b0; load = 1'b1; load_val = 4'd13;
    tick();
    chk("clamp_a",    a_cnt,  9);
    chk("clamp_full", a_full, 1);
    chk("clamp_tc",   a_tc,   0);
    chk("clamp_ovf",  a_ovf,  1);
    chk("noclamp_f",  f_cnt,  13);
    clr = 1'b1; load_val = 4'd5;
    tick();
    chk("clr_cnt", a_cnt, 0);
    chk("clr_ovf", a_ovf, 0);
    chk("clr_p",   p_cnt, 0);

    // Prescaler phase held by i_en low, then restarted by a load.
    clr = 1'b0; load = 1'b0; en = 1'b1; dir = 1'b1; sat = 1'b0;
    tick();
    tick();
    chk("hold_pre", p_cnt, 0);
    en = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("hold_mid", p_cnt, 0);
    en = 1'b1;
    tick();
    chk("hold_post", p_cnt, 1);
    tick();
    tick();
    chk("ph_pre_ld", p_cnt, 1);
    load = 1'b1; load_val = 4'd4;
    tick();
    chk("ph_ld", p_cnt, 4);
    load = 1'b0;
    tick();
    chk("ph_1", p_cnt, 4);
    tick();
    chk("ph_2", p_cnt, 4);
    tick();
    chk("ph_3", p_cnt, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
